// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum analyzer front end: RAM geometry
// defaults and the capture controller state encoding.
package spectrum_pkg;

  localparam int DEF_RAM_WIDTH     = 18;
  localparam int DEF_RAM_ADDR_BITS = 10;
  localparam int DEF_SAMPLE_WIDTH  = 12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_FILL = FILL,
    ST_HOLD = HOLD
  } cap_state_e;

endpackage

// File: rtl/sample_capture_ctrl_if.sv
// Bundle of the sample stream, RAM port A and FFT handshake signals seen by
// sample_capture_ctrl (master = the controller, slave = its environment).
interface sample_capture_ctrl_if #(
  parameter int RAM_WIDTH     = 18,
  parameter int RAM_ADDR_BITS = 10,
  parameter int SAMPLE_WIDTH  = 12
);

  // Handshakes: sample_valid qualifies sample_in for one cycle and cannot be
  // back-pressured; frame_ready stays high until frame_ack is seen, and
  // frame_ack has no effect while frame_ready is low.
  logic                     start;
  logic [SAMPLE_WIDTH-1:0]  sample_in;
  logic                     sample_valid;
  logic                     frame_ack;
  logic                     EnA;
  logic                     write_enableA;
  logic [RAM_ADDR_BITS-1:0] addrA;
  logic [RAM_WIDTH-1:0]     DinA;
  logic                     frame_ready;
  logic                     busy;
  logic                     overrun;
  logic [15:0]              frame_count;

  modport master (
    input  start, sample_in, sample_valid, frame_ack,
    output EnA, write_enableA, addrA, DinA,
    output frame_ready, busy, overrun, frame_count
  );

  modport slave (
    output start, sample_in, sample_valid, frame_ack,
    input  EnA, write_enableA, addrA, DinA,
    input  frame_ready, busy, overrun, frame_count
  );

endinterface

// File: rtl/sample_capture_ctrl_addr_bitrev.sv
// Purely combinational bit reversal of a W-bit address.
module addr_bitrev #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_addr,
  output logic [W-1:0] o_addr
);

  always_comb begin
    o_addr = '0;
    for (int i = 0; i < W; i++) begin
      o_addr[i] = i_addr[W-1-i];
    end
  end

endmodule

// File: rtl/sample_capture_ctrl.sv
// Captures one frame of sign-extended ADC samples into RAM port A and hands it
// to the FFT stage. Define SAMPLE_CAPTURE_BITREV_EN for bit-reversed addressing.
module sample_capture_ctrl
  import spectrum_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
  parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  sample_capture_ctrl_if.master bus,
  output cap_state_e           o_dbg_state
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = '1;

  cap_state_e               r_state;
  cap_state_e               w_state_next;
  logic [RAM_ADDR_BITS-1:0] r_cnt;
  logic [RAM_ADDR_BITS-1:0] w_cnt_next;
  logic                     w_accept;
  logic                     w_drop;
  logic                     w_frame_done;
  logic [RAM_ADDR_BITS-1:0] w_addr_map;
  logic [RAM_WIDTH-1:0]     w_din;

  logic                     r_en;
  logic                     r_we;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [RAM_WIDTH-1:0]     r_din;
  logic                     r_frame_ready;
  logic                     r_busy;
  logic                     r_overrun;
  logic [15:0]              r_frame_count;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_FILL;
          w_cnt_next   = '0;
        end
      end
      ST_FILL: begin
        if (bus.sample_valid) begin
          w_accept   = 1'b1;
          w_cnt_next = r_cnt + RAM_ADDR_BITS'(1);
          if (r_cnt == LAST_IDX) begin
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A sample arriving with the ack still belongs to the held frame's
        // window, so it is dropped and flagged even though we leave HOLD.
        w_drop = bus.sample_valid;
        if (bus.frame_ack) begin
          w_state_next = ST_FILL;
          w_cnt_next   = '0;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_din = RAM_WIDTH'($signed(bus.sample_in));

`ifdef SAMPLE_CAPTURE_BITREV_EN
  addr_bitrev #(
    .W (RAM_ADDR_BITS)
  ) u_addr_bitrev (
    .i_addr (r_cnt),
    .o_addr (w_addr_map)
  );
`else
  assign w_addr_map = r_cnt;
`endif

  // Status flags are registered from the next state so they line up with the
  // write that causes the transition.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_en          <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_din         <= '0;
      r_frame_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_en          <= w_accept;
      r_we          <= w_accept;
      r_frame_ready <= (w_state_next == ST_HOLD);
      r_busy        <= (w_state_next == ST_FILL);
      if (w_accept) begin
        r_addr <= w_addr_map;
        r_din  <= w_din;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign bus.EnA           = r_en;
  assign bus.write_enableA = r_we;
  assign bus.addrA         = r_addr;
  assign bus.DinA          = r_din;
  assign bus.frame_ready   = r_frame_ready;
  assign bus.busy          = r_busy;
  assign bus.overrun       = r_overrun;
  assign bus.frame_count   = r_frame_count;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_sample_capture_ctrl.sv
// Randomized bench for sample_capture_ctrl: a transaction-level frame model
// predicts RAM writes and status; a negedge monitor checks the write stream.
module tb_sample_capture_ctrl;
  import spectrum_pkg::*;

  localparam int RW = DEF_RAM_WIDTH;
  localparam int AB = DEF_RAM_ADDR_BITS;
  localparam int SW = DEF_SAMPLE_WIDTH;
  localparam int N  = 1 << AB;
  localparam int EW = AB + RW + 1;
  localparam int STW = 2 + 3 + 16;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  sample_capture_ctrl_if #(
    .RAM_WIDTH     (RW),
    .RAM_ADDR_BITS (AB),
    .SAMPLE_WIDTH  (SW)
  ) bus ();

  cap_state_e dbg_state;

  sample_capture_ctrl #(
    .RAM_WIDTH     (RW),
    .RAM_ADDR_BITS (AB),
    .SAMPLE_WIDTH  (SW)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  string phase = "reset";

  // frame model: idle unless capturing or holding a full frame
  bit m_capturing = 0;
  bit m_holding   = 0;
  int m_k         = 0;
  bit m_overrun   = 0;
  int m_frames    = 0;
  bit m_write_now = 0;

  function automatic logic [AB-1:0] ref_addr(int k);
    int r;
`ifdef SAMPLE_CAPTURE_BITREV_EN
    r = 0;
    for (int i = 0; i < AB; i++) r = r * 2 + ((k >> i) % 2);
`else
    r = k;
`endif
    return AB'(r);
  endfunction

  task automatic check(string name, logic [STW-1:0] act, logic [STW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%s]: got %h expected %h", name, phase, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(bit valid, int val, bit st, bit ack, bit rst);
    logic [RW-1:0] d;
    bus.sample_valid = valid;
    bus.sample_in    = SW'(val);
    bus.start        = st;
    bus.frame_ack    = ack;
    Rst              = rst;
    m_write_now      = 0;
    if (rst) begin
      m_capturing = 0;
      m_holding   = 0;
      m_k         = 0;
      m_overrun   = 0;
      m_frames    = 0;
    end else if (m_capturing) begin
      if (valid) begin
        d = RW'(val);
        exp_q.push_back({ref_addr(m_k), d, (m_k == N - 1)});
        m_write_now = 1;
        m_k++;
        if (m_k == N) begin
          m_capturing = 0;
          m_holding   = 1;
        end
      end
    end else if (m_holding) begin
      if (valid) m_overrun = 1;
      if (ack) begin
        m_holding   = 0;
        m_capturing = 1;
        m_k         = 0;
        m_frames    = (m_frames + 1) % 65536;
      end
    end else if (st) begin
      m_capturing = 1;
      m_k         = 0;
    end
    @(posedge Clk);
    #1;
    check("status",
          {bus.EnA, bus.write_enableA, bus.frame_ready, bus.busy, bus.overrun, bus.frame_count},
          {m_write_now, m_write_now, m_holding, m_capturing, m_overrun, 16'(m_frames)});
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, (1 << SW) - 1)) - (1 << (SW - 1));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    if (bus.EnA === 1'b1 || bus.write_enableA === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write [%s]: got addr=%0d din=%h, no write expected",
                 phase, bus.addrA, bus.DinA);
      end else begin
        e = exp_q.pop_front();
        if ({bus.EnA, bus.write_enableA, bus.addrA, bus.DinA, bus.frame_ready} !== {2'b11, e}) begin
          bad++;
          $display("FAIL write [%s]: got en=%b we=%b addr=%0d din=%h rdy=%b expected addr=%0d din=%h rdy=%b",
                   phase, bus.EnA, bus.write_enableA, bus.addrA, bus.DinA, bus.frame_ready,
                   e[EW-1 -: AB], e[RW:1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0; bus.sample_in = '0; bus.sample_valid = 0; bus.frame_ack = 0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    phase = "idle";
    for (int i = 0; i < 8; i++) step(i % 2 == 0, rand_sample(), 0, i == 5, 0);

    phase = "full_frame";
    step(0, 0, 1, 0, 0);
    for (int k = 0; k < N; k++) step(1, k - 512, 0, 0, 0);

    phase = "overrun";
    step(1, rand_sample(), 0, 0, 0);
    step(1, rand_sample(), 1, 0, 0);
    step(0, 0, 0, 1, 0);

    phase = "sparse";
    for (int i = 0; i < 3 * N; i++) step(i % 3 == 0, rand_sample(), 0, i == 7, 0);
    step(0, 0, 0, 0, 0);

    phase = "ack_with_sample";
    step(1, rand_sample(), 0, 1, 0);
    step(1, 100, 0, 0, 0);

    phase = "reset_mid_frame";
    for (int i = 0; i < 499; i++) step(1, rand_sample(), 0, 0, 0);
    step(1, rand_sample(), 0, 0, 1);
    step(1, rand_sample(), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int k = 0; k < N; k++) step(1, rand_sample(), 0, 0, 0);
    step(0, 0, 0, 1, 0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_sample(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           i == 1700);
    end

    phase = "drain";
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    @(negedge Clk);
    check("queue_empty", STW'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_capture_ctrl.md
Name: sample_capture_ctrl

Overview:
- Upstream feeder for the 18-bit dual-port input-data RAM of the spectrum analyzer.
- Accepts a stream of signed ADC samples with a valid strobe and sign-extends each to RAM_WIDTH.
- Writes one frame of 2**RAM_ADDR_BITS samples through RAM port A, then hands the frame to the FFT stage with a ready/ack handshake.
- Frames samples, counts them, and flags samples that arrive while a frame is held.

Parameters:
- RAM_WIDTH, 18, RAM data word width.
- RAM_ADDR_BITS, 10, RAM address width; frame length N = 2**RAM_ADDR_BITS.
- SAMPLE_WIDTH, 12, ADC sample width; must be <= RAM_WIDTH.

Ports:
- Clk  input  1  single clock; all logic on posedge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms capture from IDLE.
- sample_in  input  SAMPLE_WIDTH  signed two's-complement ADC sample.
- sample_valid  input  1  sample_in is valid this cycle.
- frame_ack  input  1  FFT stage has consumed the frame.
- EnA  output  1  RAM port A enable.
- write_enableA  output  1  RAM port A write enable.
- addrA  output  RAM_ADDR_BITS  RAM port A address.
- DinA  output  RAM_WIDTH  RAM port A write data.
- frame_ready  output  1  a full frame is in RAM.
- busy  output  1  state is FILL.
- overrun  output  1  sticky: a sample was dropped in HOLD.
- frame_count  output  16  frames completed, wrapping.

Behaviour:
- Reset: all outputs 0, state IDLE, sample counter 0.
  - Rst mid-FILL or mid-HOLD aborts the frame immediately. No further writes occur. The partial frame is abandoned.
- Reset is the only way to clear overrun.
- States:
  - IDLE: sample_valid is ignored. start moves to FILL.
  - FILL: each sample_valid writes one word. When the counter is N-1 at an accepted sample, go to HOLD.
  - HOLD: frame_ready = 1. Sample_valid here sets overrun and the sample is dropped.
    - frame_ack → go to FILL, counter = 0, frame_count += 1.
    - frame_ack is ignored outside HOLD.
- Continuous operation: after ack, capture resumes in FILL without a new start. start is ignored outside IDLE.
- Write timing:
  - EnA, write_enableA, addrA and DinA are registered.
  - A sample accepted in cycle t produces EnA = write_enableA = 1 in cycle t+1 with its address and data. Both strobes are 0 otherwise.
  - Exactly N write pulses per frame.
- Data: DinA = sample_in sign-extended from SAMPLE_WIDTH to RAM_WIDTH bits.
- Address: addrA = sample index k, 0..N-1, natural order. The counter wraps to 0 on entry to FILL.
- Last sample and frame_ready:
  - The last sample accepted in cycle t gives its write in cycle t+1 and frame_ready = 1 in cycle t+1, in the same cycle as that write.
  - The RAM registers its address internally, so the FFT must wait at least 2 cycles after frame_ready before reading.
- Simultaneous frame_ack and sample_valid in HOLD:
  - The sample is dropped and overrun is set.
  - The state still moves to FILL.
- frame_count wraps from 0xFFFF to 0.
- busy = (state == FILL), registered alongside the state.

Optional Feature:
- Macro: SAMPLE_CAPTURE_BITREV_EN.
- Defined: addrA = bit-reverse of k over RAM_ADDR_BITS, so the RAM holds decimation-in-time input order.
  - Example with RAM_ADDR_BITS = 10: k = 1 → addr 512; k = 3 → 768.
- Undefined: natural order addrA = k.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package spectrum_pkg holds:
  - RAM_WIDTH and RAM_ADDR_BITS defaults.
  - State encoding localparams: IDLE = 2'd0, FILL = 2'd1, HOLD = 2'd2.
- One sub-module: addr_bitrev, a purely combinational parameterized bit reversal.
  - Instantiated only under SAMPLE_CAPTURE_BITREV_EN.

Test Plan:
- Reset and idle:
  - Stimulus: Rst for 2 cycles, then sample_valid toggling with no start.
  - Required: EnA = 0 and write_enableA = 0 throughout; all outputs remain 0.
- Full frame:
  - Stimulus: start, then 1024 consecutive valid samples k = 0..1023 with value k−512.
  - Required: 1024 writes; addrA = k; DinA = sign-extended value (e.g. k = 0 gives 18'h3FE00); frame_ready rises in the cycle of the write to addr 1023.
- Sparse input:
  - Stimulus: sample_valid every 3rd cycle.
  - Required: each write is exactly 1 cycle after its valid; no gaps in the address sequence.
- Overrun and handshake:
  - Stimulus: in HOLD, drive 2 samples, then frame_ack.
  - Required: overrun = 1 (sticky); no writes during HOLD; frame_count = 1; next sample writes addr 0.
- Reset mid-frame:
  - Stimulus: Rst after 500 samples, then start and a full frame.
  - Required: no write in the cycle after Rst; new frame starts at addr 0; frame_count = 1 after ack.
- BITREV build:
  - Stimulus: first 4 samples of a frame.
  - Required: addresses 0, 512, 256, 768.
